mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the instruction fetch unit and the load/store unit of the multi-cycle core.
- Arbitrates requests round-robin and sequences each access through a fixed-latency memory.
- Returns a one-cycle acknowledge plus read data to the winning requester.
- Honours a branch flush that squashes an in-flight instruction fetch.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..15

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
flush  in  1  branch taken; squashes acknowledge of an in-flight fetch
f_req  in  1  fetch request, held until f_ack
f_addr  in  ADDR_W  fetch address
f_ack  out  1  one-cycle fetch completion pulse
f_rdata  out  DATA_W  fetched instruction, valid when f_ack=1
l_req  in  1  load/store request, held until l_ack
l_we  in  1  1=store, 0=load
l_addr  in  ADDR_W  load/store address
l_wdata  in  DATA_W  store data
l_ack  out  1  one-cycle load/store completion pulse
l_rdata  out  DATA_W  load data, valid when l_ack=1 and the access was a load
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
busy  out  1  high whenever state is not IDLE

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous, active-high.
- Reset values:
  - state=IDLE.
  - All outputs 0.
  - Internal last_grant=LSU, so fetch wins the first tie.
  - Latency counter 0; squash flag 0.
- Reset mid-access abandons the access. No ack is issued.
- All outputs are registered.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requests: grant the requester that is not last_grant, then set last_grant to the winner.
  - On grant: latch address, we (fetch is always a read) and wdata into mem_addr/mem_we/mem_wdata; load counter with MEM_LAT-1; go to ACCESS.
- ACCESS:
  - Lasts exactly MEM_LAT cycles.
  - mem_en=1 only in the first ACCESS cycle. mem_we=1 only in that cycle, and only for stores.
  - mem_addr and mem_wdata stay stable for the whole of ACCESS.
  - Counter decrements each cycle. When it is 0: capture mem_rdata into the granted rdata output (loads and fetches only), then go to RESP.
- RESP:
  - Pulse the granted ack for one cycle, then go to IDLE.
  - rdata outputs hold their value until the next capture.
- Timing: request seen in IDLE at cycle t gives mem_en at t+1 and ack at t+MEM_LAT+1. Earliest next grant is t+MEM_LAT+2.
- Requester protocol:
  - A requester drops req in the cycle after its ack.
  - A req still high in the IDLE cycle after RESP is treated as a new request.
  - A req deasserted during ACCESS is ignored; the access still completes and acks.
- flush:
  - During a fetch grant (any ACCESS cycle, or RESP) it sets the squash flag. The memory access completes, but f_ack is suppressed and f_rdata is not updated. The flag clears on return to IDLE.
  - flush in IDLE, or during an LSU grant, has no effect.
  - flush with f_req in IDLE does not block the grant.
- Stores acknowledge normally; l_rdata is unchanged.
- f_ack and l_ack are never high in the same cycle. mem_en never asserts while busy except in the first ACCESS cycle.

Test Plan:
1. Single fetch, MEM_LAT=2:
   - Stimulus: f_req=1, f_addr=0x100 at cycle 0; memory returns 0xDEADBEEF.
   - Required: mem_en=1, mem_addr=0x100 at cycle 1; f_ack=1 with f_rdata=0xDEADBEEF at cycle 3; busy high for cycles 1..3.
2. Tie after reset:
   - Stimulus: f_req and l_req both raised at cycle 0 and held until acked.
   - Required: fetch acked at cycle 3, LSU granted at cycle 4, l_ack at cycle 7; a second simultaneous pair grants fetch first again.
3. Store:
   - Stimulus: l_we=1, l_addr=0x40, l_wdata=0x1234.
   - Required: mem_en=mem_we=1 for exactly one cycle with wdata 0x1234; l_ack pulses; l_rdata unchanged.
4. Flush squash:
   - Stimulus: fetch granted, flush=1 during the second ACCESS cycle.
   - Required: f_ack stays 0 and f_rdata holds its old value; the FSM returns to IDLE on schedule; a pending l_req is granted next.
5. Reset mid-access:
   - Stimulus: assert reset during an ACCESS cycle of a load.
   - Required: all outputs 0 immediately (asynchronous); no l_ack after release; the first tie after release goes to fetch.
6. MEM_LAT=1 back-to-back loads:
   - Stimulus: l_req held across two loads.
   - Required: ack every 3 cycles; no overlapping mem_en.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : Requester, memory and status signals of the shared memory port.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              flush;
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_ack;
    logic [DATA_W-1:0] f_rdata;
    logic              l_req;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              l_ack;
    logic [DATA_W-1:0] l_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    // Requesters and memory side
    modport master (
        output flush, f_req, f_addr, l_req, l_we, l_addr, l_wdata, mem_rdata,
        input  f_ack, f_rdata, l_ack, l_rdata, mem_en, mem_we, mem_addr,
               mem_wdata, busy
    );

    // Arbiter side
    modport slave (
        input  flush, f_req, f_addr, l_req, l_we, l_addr, l_wdata, mem_rdata,
        output f_ack, f_rdata, l_ack, l_rdata, mem_en, mem_we, mem_addr,
               mem_wdata, busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Round-robin fetch/LSU arbiter for a fixed-latency memory port.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_RESP   = 2'd2;
    localparam logic [3:0] c_LAT_M1 = 4'(MEM_LAT - 1);

    logic [1:0]        r_state;
    logic              r_last_lsu;
    logic              r_grant_lsu;
    logic              r_store;
    logic [3:0]        r_cnt;
    logic              r_squash;
    logic              r_f_ack;
    logic              r_l_ack;
    logic [DATA_W-1:0] r_f_rdata;
    logic [DATA_W-1:0] r_l_rdata;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_busy;

    logic              w_any_req;
    logic              w_pick_lsu;

    // On a tie the LSU wins only if fetch was granted last
    assign w_any_req  = bus.f_req | bus.l_req;
    assign w_pick_lsu = bus.l_req & (~bus.f_req | ~r_last_lsu);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_last_lsu  <= 1'b1;
            r_grant_lsu <= 1'b0;
            r_store     <= 1'b0;
            r_cnt       <= 4'd0;
            r_squash    <= 1'b0;
            r_f_ack     <= 1'b0;
            r_l_ack     <= 1'b0;
            r_f_rdata   <= '0;
            r_l_rdata   <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_squash <= 1'b0;
                    if (w_any_req) begin
                        r_state     <= c_ACCESS;
                        r_busy      <= 1'b1;
                        r_mem_en    <= 1'b1;
                        r_grant_lsu <= w_pick_lsu;
                        r_last_lsu  <= w_pick_lsu;
                        r_store     <= w_pick_lsu & bus.l_we;
                        r_mem_we    <= w_pick_lsu & bus.l_we;
                        r_mem_addr  <= w_pick_lsu ? bus.l_addr : bus.f_addr;
                        r_mem_wdata <= w_pick_lsu ? bus.l_wdata : '0;
                        r_cnt       <= c_LAT_M1;
                    end
                end
                c_ACCESS: begin
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                    if (bus.flush && !r_grant_lsu) begin
                        r_squash <= 1'b1;
                    end
                    if (r_cnt == 4'd0) begin
                        r_state <= c_RESP;
                        if (r_grant_lsu) begin
                            r_l_ack <= 1'b1;
                            if (!r_store) begin
                                r_l_rdata <= bus.mem_rdata;
                            end
                        // A flush in the final cycle must also squash
                        end else if (!(r_squash || bus.flush)) begin
                            r_f_ack   <= 1'b1;
                            r_f_rdata <= bus.mem_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_RESP: begin
                    r_f_ack  <= 1'b0;
                    r_l_ack  <= 1'b0;
                    r_busy   <= 1'b0;
                    r_squash <= 1'b0;
                    r_state  <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.f_ack     = r_f_ack;
    assign bus.f_rdata   = r_f_rdata;
    assign bus.l_ack     = r_l_ack;
    assign bus.l_rdata   = r_l_rdata;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Scoreboard bench for mem_port_arbiter at MEM_LAT=2 and MEM_LAT=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    typedef struct {
        bit          lsu;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    exp_t        sb[$];
    exp_t        sb1[$];
    logic [31:0] model_f_rdata;
    logic [31:0] model_l_rdata;
    int          age0 = 100;
    int          age1 = 100;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) u_if ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) u_if1 ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rd_model(input logic [31:0] addr);
        if (addr == 32'h100) return 32'hDEADBEEF;
        return addr * 32'h9E3779B1 + 32'h1357;
    endfunction

    // Memory models: data is valid only MEM_LAT-1 cycles after the mem_en cycle
    always @(posedge clk) age0 <= u_if.mem_en ? 1 : (age0 < 100 ? age0 + 1 : age0);
    always @(posedge clk) age1 <= u_if1.mem_en ? 1 : (age1 < 100 ? age1 + 1 : age1);
    assign u_if.mem_rdata  = ((u_if.mem_en ? 0 : age0) == 1) ? rd_model(u_if.mem_addr) : 32'hBAD0BAD0;
    assign u_if1.mem_rdata = ((u_if1.mem_en ? 0 : age1) == 0) ? rd_model(u_if1.mem_addr) : 32'hBAD0BAD0;

    exp_t e0;
    always @(negedge clk) begin
        if (!reset && (u_if.f_ack || u_if.l_ack)) begin
            total++;
            if (u_if.f_ack && u_if.l_ack) begin
                bad++;
                $display("FAIL ack_overlap cycle=%0d f_ack=1 l_ack=1 required one ack", cyc);
            end else if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_ack cycle=%0d f_ack=%b l_ack=%b required none",
                         cyc, u_if.f_ack, u_if.l_ack);
            end else begin
                e0 = sb.pop_front();
                if (u_if.l_ack !== e0.lsu || cyc !== e0.cyc ||
                    (u_if.l_ack ? u_if.l_rdata : u_if.f_rdata) !== e0.data) begin
                    bad++;
                    $display("FAIL ack_lat2 got lsu=%b cyc=%0d data=%h required lsu=%b cyc=%0d data=%h",
                             u_if.l_ack, cyc, u_if.l_ack ? u_if.l_rdata : u_if.f_rdata,
                             e0.lsu, e0.cyc, e0.data);
                end
            end
        end
    end

    exp_t e1;
    always @(negedge clk) begin
        if (!reset && (u_if1.f_ack || u_if1.l_ack)) begin
            total++;
            if (sb1.size() == 0) begin
                bad++;
                $display("FAIL unexpected_ack_lat1 cycle=%0d f_ack=%b l_ack=%b required none",
                         cyc, u_if1.f_ack, u_if1.l_ack);
            end else begin
                e1 = sb1.pop_front();
                if (u_if1.l_ack !== e1.lsu || u_if1.f_ack === 1'b1 || cyc !== e1.cyc ||
                    u_if1.l_rdata !== e1.data) begin
                    bad++;
                    $display("FAIL ack_lat1 got l_ack=%b cyc=%0d data=%h required lsu=%b cyc=%0d data=%h",
                             u_if1.l_ack, cyc, u_if1.l_rdata, e1.lsu, e1.cyc, e1.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        u_if.flush = 0;  u_if.f_req = 0;  u_if.f_addr = 0;
        u_if.l_req = 0;  u_if.l_we = 0;   u_if.l_addr = 0;  u_if.l_wdata = 0;
        u_if1.flush = 0; u_if1.f_req = 0; u_if1.f_addr = 0;
        u_if1.l_req = 0; u_if1.l_we = 0;  u_if1.l_addr = 0; u_if1.l_wdata = 0;
    endtask

    // Holds requests until each side has seen its ack count, then drops them
    task automatic wait_acks(input int nf, input int nl, input int budget, output bit ok);
        bit df, dl;
        for (int i = 0; i < budget && (nf > 0 || nl > 0); i++) begin
            @(negedge clk);
            df = u_if.f_ack && nf > 0;
            dl = u_if.l_ack && nl > 0;
            if (df) nf--;
            if (dl) nl--;
            step();
            if (df && nf == 0) u_if.f_req = 0;
            if (dl && nl == 0) u_if.l_req = 0;
        end
        ok = (nf == 0 && nl == 0);
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        model_f_rdata = 0;
        model_l_rdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({u_if.f_ack, u_if.l_ack, u_if.mem_en, u_if.mem_we, u_if.busy, u_if.f_rdata,
             u_if.l_rdata, u_if.mem_addr, u_if.mem_wdata} !== '0) begin
            bad++;
            $display("FAIL reset_outputs busy=%b mem_en=%b f_rdata=%h required all zero",
                     u_if.busy, u_if.mem_en, u_if.f_rdata);
        end
        #1 reset = 0;
        step();
    endtask

    task automatic tie_pair(input logic [31:0] fa, input logic [31:0] la);
        bit ok;
        int c;
        c = cyc;
        u_if.f_req = 1; u_if.f_addr = fa;
        u_if.l_req = 1; u_if.l_we = 0; u_if.l_addr = la;
        sb.push_back('{lsu: 1'b0, data: rd_model(fa), cyc: c + 3});
        sb.push_back('{lsu: 1'b1, data: rd_model(la), cyc: c + 7});
        model_f_rdata = rd_model(fa);
        model_l_rdata = rd_model(la);
        wait_acks(1, 1, 14, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL tie_timeout acks_done=0 required 1");
        end
    endtask

    task automatic test_tie();
        tie_pair(32'h1000, 32'h2000);
        step();
        tie_pair(32'h1004, 32'h2008);
    endtask

    task automatic test_single_fetch();
        int c;
        step();
        c = cyc;
        u_if.f_req = 1; u_if.f_addr = 32'h100;
        sb.push_back('{lsu: 1'b0, data: 32'hDEADBEEF, cyc: c + 3});
        model_f_rdata = 32'hDEADBEEF;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            total++;
            if (u_if.busy !== (k >= 1 && k <= 3)) begin
                bad++;
                $display("FAIL fetch_busy k=%0d got %b required %b", k, u_if.busy, (k >= 1 && k <= 3));
            end
            if (k == 1) begin
                total++;
                if ({u_if.mem_en, u_if.mem_we, u_if.mem_addr} !== {2'b10, 32'h100}) begin
                    bad++;
                    $display("FAIL fetch_issue got en=%b we=%b addr=%h required en=1 we=0 addr=00000100",
                             u_if.mem_en, u_if.mem_we, u_if.mem_addr);
                end
            end
            if (k == 2) begin
                total++;
                if (u_if.mem_en !== 1'b0 || u_if.mem_addr !== 32'h100) begin
                    bad++;
                    $display("FAIL fetch_hold got en=%b addr=%h required en=0 addr=00000100",
                             u_if.mem_en, u_if.mem_addr);
                end
            end
            step();
            if (k == 3) u_if.f_req = 0;
        end
    endtask

    task automatic test_store();
        int c;
        step();
        c = cyc;
        u_if.l_req = 1; u_if.l_we = 1; u_if.l_addr = 32'h40; u_if.l_wdata = 32'h1234;
        sb.push_back('{lsu: 1'b1, data: model_l_rdata, cyc: c + 3});
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            total++;
            if ({u_if.mem_en, u_if.mem_we} !== ((k == 1) ? 2'b11 : 2'b00)) begin
                bad++;
                $display("FAIL store_strobe k=%0d got en=%b we=%b required %b",
                         k, u_if.mem_en, u_if.mem_we, (k == 1));
            end
            if (k == 1 || k == 2) begin
                total++;
                if (u_if.mem_addr !== 32'h40 || u_if.mem_wdata !== 32'h1234) begin
                    bad++;
                    $display("FAIL store_bus k=%0d got addr=%h wdata=%h required 00000040 00001234",
                             k, u_if.mem_addr, u_if.mem_wdata);
                end
            end
            step();
            if (k == 3) begin
                u_if.l_req = 0;
                u_if.l_we = 0;
            end
        end
    endtask

    task automatic test_flush();
        int c;
        step();
        c = cyc;
        u_if.f_req = 1; u_if.f_addr = 32'h200;
        u_if.l_req = 1; u_if.l_we = 0; u_if.l_addr = 32'h300;
        sb.push_back('{lsu: 1'b1, data: rd_model(32'h300), cyc: c + 7});
        model_l_rdata = rd_model(32'h300);
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            if (k == 3) begin
                total++;
                if (u_if.busy !== 1'b1 || u_if.f_ack !== 1'b0) begin
                    bad++;
                    $display("FAIL flush_resp got busy=%b f_ack=%b required busy=1 f_ack=0",
                             u_if.busy, u_if.f_ack);
                end
            end
            if (k == 4) begin
                total++;
                if (u_if.busy !== 1'b0 || u_if.f_rdata !== model_f_rdata) begin
                    bad++;
                    $display("FAIL flush_idle got busy=%b f_rdata=%h required busy=0 f_rdata=%h",
                             u_if.busy, u_if.f_rdata, model_f_rdata);
                end
            end
            if (k == 5) begin
                total++;
                if (u_if.mem_en !== 1'b1 || u_if.mem_addr !== 32'h300) begin
                    bad++;
                    $display("FAIL flush_next_grant got en=%b addr=%h required en=1 addr=00000300",
                             u_if.mem_en, u_if.mem_addr);
                end
            end
            step();
            if (k == 1) u_if.flush = 1;
            if (k == 2) begin
                u_if.flush = 0;
                u_if.f_req = 0;
            end
            if (k == 7) u_if.l_req = 0;
        end
    endtask

    task automatic test_reset_mid_access();
        step();
        u_if.l_req = 1; u_if.l_we = 0; u_if.l_addr = 32'h500;
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1;
        #1;
        total++;
        if ({u_if.f_ack, u_if.l_ack, u_if.mem_en, u_if.mem_we, u_if.busy, u_if.f_rdata,
             u_if.l_rdata, u_if.mem_addr, u_if.mem_wdata} !== '0) begin
            bad++;
            $display("FAIL async_reset busy=%b mem_addr=%h l_rdata=%h required all zero",
                     u_if.busy, u_if.mem_addr, u_if.l_rdata);
        end
        u_if.l_req = 0;
        model_f_rdata = 0;
        model_l_rdata = 0;
        @(posedge clk);
        @(negedge clk);
        #1 reset = 0;
        step();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (u_if.l_ack !== 1'b0 || u_if.busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_abandon k=%0d got l_ack=%b busy=%b required 0 0",
                         k, u_if.l_ack, u_if.busy);
            end
            step();
        end
        tie_pair(32'h600, 32'h700);
    endtask

    task automatic test_back_to_back();
        int c;
        step();
        c = cyc;
        u_if1.l_req = 1; u_if1.l_we = 0; u_if1.l_addr = 32'h800;
        sb1.push_back('{lsu: 1'b1, data: rd_model(32'h800), cyc: c + 2});
        sb1.push_back('{lsu: 1'b1, data: rd_model(32'h804), cyc: c + 5});
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            total++;
            if (u_if1.mem_en !== (k == 1 || k == 4)) begin
                bad++;
                $display("FAIL lat1_mem_en k=%0d got %b required %b", k, u_if1.mem_en, (k == 1 || k == 4));
            end
            step();
            if (k == 2) u_if1.l_addr = 32'h804;
            if (k == 5) u_if1.l_req = 0;
        end
    endtask

    initial begin
        test_reset();
        test_tie();
        test_single_fetch();
        test_store();
        test_flush();
        test_reset_mid_access();
        test_back_to_back();
        repeat (4) step();
        total++;
        if (sb.size() != 0 || sb1.size() != 0) begin
            bad++;
            $display("FAIL pending_acks got %0d/%0d outstanding required 0/0", sb.size(), sb1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish required finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
